// File: rtl/nor_wb_arbiter.sv
// nor_wb_arbiter
// Two-master Wishbone (pipelined) arbiter in front of the NOR flash controller.
// Master 0 is the QSPI command FSM, master 1 the debug/scan requester.
// Ownership is held for the whole bus cycle (no pre-emption). Between owners the
// FSM passes through a one-clock TURN state. Simultaneous requests from IDLE
// alternate between the masters.
// Optional ack-wait watchdog: define NOR_WB_ARBITER_TIMEOUT_EN to build it.
// Without the macro, timeout_o is tied low and the arbiter waits forever for ack.
module nor_wb_arbiter #(
  parameter int DATABITS       = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // master 0
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [31:0]         m0_adr_i,
  input  logic [DATABITS-1:0] m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_stall_o,
  output logic [DATABITS-1:0] m0_dat_o,
  // master 1
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [31:0]         m1_adr_i,
  input  logic [DATABITS-1:0] m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_stall_o,
  output logic [DATABITS-1:0] m1_dat_o,
  // slave (NOR controller)
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [31:0]         s_adr_o,
  output logic [DATABITS-1:0] s_dat_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_stall_i,
  input  logic [DATABITS-1:0] s_dat_i,
  // status
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  // Reject an out-of-range watchdog limit at elaboration time.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
    $error("nor_wb_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t      r_state;
  logic        r_last;         // master granted most recently (1 -> m0 wins a tie)
  logic        r_arm;          // set one clock after reset release; gates first grant
  logic [4:0]  r_outstanding;  // accepted strobes still waiting for ack/err

  logic        w_own0;
  logic        w_own1;
  logic        w_owning;
  logic        w_own_cyc;
  logic        w_accept;
  logic        w_resp;
  logic        w_leave;
  logic        w_expire;

  assign w_own0   = (r_state == ST_OWN0);
  assign w_own1   = (r_state == ST_OWN1);
  assign w_owning = w_own0 | w_own1;

  // Owner's cyc line; low outside the owner states.
  always_comb begin
    w_own_cyc = 1'b0;
    case (r_state)
      ST_OWN0: w_own_cyc = m0_cyc_i;
      ST_OWN1: w_own_cyc = m1_cyc_i;
      default: w_own_cyc = 1'b0;
    endcase
  end

  // A strobe is taken by the slave when it is not stalling; responses only count
  // while a master owns the bus (anything arriving in IDLE/TURN is dropped).
  assign w_accept = s_stb_o & ~s_stall_i;
  assign w_resp   = w_owning & (s_ack_i | s_err_i);
  // Ownership ends when the owner drops cyc (possibly an abort) or the watchdog fires.
  assign w_leave  = w_owning & (w_expire | ~w_own_cyc);

  // Arbitration FSM: IDLE picks an owner, OWNx holds until release/expiry, TURN is a
  // one-clock gap so the other master gets a fair look in IDLE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_arm   <= 1'b0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_arm && m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= ST_OWN0;
          end else if (r_arm && m1_cyc_i) begin
            r_state <= ST_OWN1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_OWN0: begin
          if (w_expire || !m0_cyc_i) begin
            r_state <= ST_TURN;
            r_last  <= 1'b0;
          end else begin
            r_state <= ST_OWN0;
          end
        end
        ST_OWN1: begin
          if (w_expire || !m1_cyc_i) begin
            r_state <= ST_TURN;
            r_last  <= 1'b1;
          end else begin
            r_state <= ST_OWN1;
          end
        end
        ST_TURN: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-transaction counter: saturating at 0 and 31, zeroed on the way to TURN.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_outstanding <= 5'd0;
    end else if (w_leave) begin
      r_outstanding <= 5'd0;
    end else if (w_owning) begin
      case ({w_accept, w_resp})
        2'b10: begin
          if (r_outstanding != 5'd31) begin
            r_outstanding <= r_outstanding + 5'd1;
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        2'b01: begin
          if (r_outstanding != 5'd0) begin
            r_outstanding <= r_outstanding - 5'd1;
          end else begin
            r_outstanding <= r_outstanding;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end else begin
      r_outstanding <= 5'd0;
    end
  end

`ifdef NOR_WB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] LP_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wdog;

  // Expiry is a decode of registered state, so err/timeout are glitch-free.
  assign w_expire = w_owning & (r_wdog == LP_WDOG_LAST);

  // Ack-wait watchdog: counts owner clocks with work pending and no response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wdog <= 16'd0;
    end else if (!w_owning || w_leave || w_resp) begin
      r_wdog <= 16'd0;
    end else if (r_outstanding != 5'd0) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= r_wdog;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  assign timeout_o = w_expire;

  // One-hot owner indication.
  always_comb begin
    grant_o = 2'b00;
    case (r_state)
      ST_OWN0: grant_o = 2'b01;
      ST_OWN1: grant_o = 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Slave-side mux: owner's request lines, all zero in IDLE/TURN.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'h0000_0000;
    s_dat_o = {DATABITS{1'b0}};
    case (r_state)
      ST_OWN0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      ST_OWN1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = 32'h0000_0000;
        s_dat_o = {DATABITS{1'b0}};
      end
    endcase
  end

  // Master 0 responses: slave lines when owning (err forced on expiry), else parked.
  always_comb begin
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m0_dat_o   = {DATABITS{1'b0}};
    if (w_own0) begin
      m0_ack_o   = s_ack_i & ~w_expire;
      m0_err_o   = s_err_i | w_expire;
      m0_stall_o = s_stall_i;
      m0_dat_o   = s_dat_i;
    end else begin
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_stall_o = 1'b1;
      m0_dat_o   = {DATABITS{1'b0}};
    end
  end

  // Master 1 responses: slave lines when owning (err forced on expiry), else parked.
  always_comb begin
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    m1_dat_o   = {DATABITS{1'b0}};
    if (w_own1) begin
      m1_ack_o   = s_ack_i & ~w_expire;
      m1_err_o   = s_err_i | w_expire;
      m1_stall_o = s_stall_i;
      m1_dat_o   = s_dat_i;
    end else begin
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_stall_o = 1'b1;
      m1_dat_o   = {DATABITS{1'b0}};
    end
  end

endmodule

// File: tb/tb_nor_wb_arbiter.sv
// Directed bench for nor_wb_arbiter with a response scoreboard.
// Stimulus pushes each expected master response; a monitor pops on every
// ack/err seen at a master port and compares.
module tb_nor_wb_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we;
  logic [31:0]   m0_adr;
  logic [DW-1:0] m0_wdat, m0_rdat;
  logic          m0_ack, m0_err, m0_stall;
  logic          m1_cyc, m1_stb, m1_we;
  logic [31:0]   m1_adr;
  logic [DW-1:0] m1_wdat, m1_rdat;
  logic          m1_ack, m1_err, m1_stall;
  logic          s_cyc, s_stb, s_we;
  logic [31:0]   s_adr;
  logic [DW-1:0] s_wdat, s_rdat;
  logic          s_ack, s_err, s_stall;
  logic [1:0]    grant;
  logic          tmo;

  int n_vec = 0;
  int n_err = 0;
  int n_acc;

  // {master, ack, err, data}
  typedef struct packed {
    logic          mst;
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;
  rsp_t exp_q[$];

  nor_wb_arbiter #(.DATABITS(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_stall_o(m0_stall), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_stall_o(m1_stall), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
    .s_dat_i(s_rdat), .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 32'h0; m0_wdat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 32'h0; m1_wdat = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_rdat = '0;
  endtask

  // Reset, release, then let the arming edge pass: next edge may grant.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();
  endtask

  // Monitor: every ack/err at a master port must match the head of the queue.
  always @(negedge clk) begin
    rsp_t act, e;
    if (m0_ack || m0_err || m1_ack || m1_err) begin
      act.mst = m1_ack | m1_err;
      act.ack = m0_ack | m1_ack;
      act.err = m0_err | m1_err;
      act.dat = (m0_ack | m0_err) ? m0_rdat : m1_rdat;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got %h, wanted no response", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL rsp_compare: got %h, wanted %h", act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got no finish, wanted finish before 200us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    // ---- reset values, then grant latency after release ----
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    mid();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_scyc", 32'(s_cyc), 32'h0);
    chk("rst_m0_stall", 32'(m0_stall), 32'h1);
    chk("rst_m1_stall", 32'(m1_stall), 32'h1);
    chk("rst_timeout", 32'(tmo), 32'h0);
    chk("rst_m0_dat", 32'(m0_rdat), 32'h0);
    cyc();
    reset = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h0000_0100;
    cyc();
    mid();
    chk("rel_first_edge", 32'(grant), 32'h0);
    cyc();
    mid();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_scyc", 32'(s_cyc), 32'h1);
    chk("rd_sadr", s_adr, 32'h0000_0100);
    chk("rd_m1_stall", 32'(m1_stall), 32'h1);
    cyc();                      // strobe accepted on this edge
    m0_stb = 1'b0;
    mid();
    chk("rd_outst1", 32'(dut.r_outstanding), 32'd1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      mid();
      chk("rd_m1_stall_wait", 32'(m1_stall), 32'h1);
    end
    cyc();
    s_ack = 1'b1; s_rdat = 16'hBEEF;
    exp_q.push_back('{mst: 1'b0, ack: 1'b1, err: 1'b0, dat: 16'hBEEF});
    mid();
    chk("rd_m0_dat", 32'(m0_rdat), 32'h0000_BEEF);
    chk("rd_m1_stall_ack", 32'(m1_stall), 32'h1);
    cyc();
    s_ack = 1'b0; s_rdat = '0; m0_cyc = 1'b0;
    mid();
    chk("rd_outst0", 32'(dut.r_outstanding), 32'd0);
    chk("rd_release_scyc", 32'(s_cyc), 32'h0);
    cyc();
    mid();
    chk("rd_turn_grant", 32'(grant), 32'h0);
    cyc();

    // ---- simultaneous requests, no pre-emption, round robin ----
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    cyc();
    mid();
    chk("rr_first_m0", 32'(grant), 32'h1);
    chk("rr_m1_stall", 32'(m1_stall), 32'h1);
    cyc();
    mid();
    chk("rr_no_preempt", 32'(grant), 32'h1);
    cyc();
    m0_cyc = 1'b0;
    cyc();
    mid();
    chk("rr_turn", 32'(grant), 32'h0);
    chk("rr_turn_m1_stall", 32'(m1_stall), 32'h1);
    cyc();
    mid();
    chk("rr_idle", 32'(grant), 32'h0);
    cyc();
    mid();
    chk("rr_m1_granted", 32'(grant), 32'h2);
    cyc();
    m1_cyc = 1'b0;
    cyc();
    cyc();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    cyc();
    mid();
    chk("rr_m0_again", 32'(grant), 32'h1);
    cyc();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    cyc();
    cyc();

    // ---- m1 pipelined reads with one stalled strobe ----
    begin
      logic        stall_seq [5];
      logic [31:0] adr_seq   [5];
      stall_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      adr_seq   = '{32'h200, 32'h204, 32'h204, 32'h208, 32'h20C};
      n_acc = 0;
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = adr_seq[0]; s_stall = stall_seq[0];
      cyc();
      for (int i = 0; i < 5; i++) begin
        if (i > 0) begin
          cyc();
          m1_adr = adr_seq[i];
          s_stall = stall_seq[i];
        end
        mid();
        if (s_stb && !s_stall) n_acc++;
        chk("pl_grant", 32'(grant), 32'h2);
        chk("pl_m0_stall", 32'(m0_stall), 32'h1);
      end
    end
    cyc();
    m1_stb = 1'b0; s_stall = 1'b0;
    mid();
    chk("pl_accepted", 32'(n_acc), 32'd4);
    chk("pl_outst4", 32'(dut.r_outstanding), 32'd4);
    for (int j = 0; j < 4; j++) begin
      cyc();
      s_ack = 1'b1; s_rdat = 16'hA000 + 16'(j);
      exp_q.push_back('{mst: 1'b1, ack: 1'b1, err: 1'b0, dat: 16'hA000 + 16'(j)});
      mid();
    end
    cyc();
    s_ack = 1'b0; s_rdat = '0;
    mid();
    chk("pl_outst0", 32'(dut.r_outstanding), 32'd0);
    cyc();
    m1_cyc = 1'b0;
    cyc();
    cyc();

    // ---- m0 abort with two reads outstanding, late ack discarded ----
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0300;
    cyc();
    cyc();
    cyc();
    m0_stb = 1'b0; m0_cyc = 1'b0;
    mid();
    chk("ab_outst2", 32'(dut.r_outstanding), 32'd2);
    chk("ab_scyc_low", 32'(s_cyc), 32'h0);
    chk("ab_grant_still", 32'(grant), 32'h1);
    cyc();
    s_ack = 1'b1; s_rdat = 16'h1234;
    mid();
    chk("ab_turn_m0_ack", 32'(m0_ack), 32'h0);
    chk("ab_turn_m1_ack", 32'(m1_ack), 32'h0);
    chk("ab_turn_outst", 32'(dut.r_outstanding), 32'd0);
    cyc();
    mid();
    chk("ab_idle_m0_ack", 32'(m0_ack), 32'h0);
    cyc();
    s_ack = 1'b0; s_rdat = '0;
    mid();
    chk("ab_idle_outst", 32'(dut.r_outstanding), 32'd0);

    // ---- reset between edges during an m1 write ----
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    m1_adr = 32'h0000_0400; m1_wdat = 16'h5A5A; s_stall = 1'b1;
    cyc();
    mid();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_swe", 32'(s_we), 32'h1);
    chk("wr_sdat", 32'(s_wdat), 32'h0000_5A5A);
    @(posedge clk);
    #3 reset = 1'b1;
    s_ack = 1'b1;
    #1;
    chk("ar_scyc", 32'(s_cyc), 32'h0);
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_m1_stall", 32'(m1_stall), 32'h1);
    chk("ar_m1_ack", 32'(m1_ack), 32'h0);
    cyc();
    cyc();
    clear_inputs();
    reset = 1'b0;
    cyc();

`ifdef NOR_WB_ARBITER_TIMEOUT_EN
    // ---- watchdog: slave never answers ----
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0500;
    cyc();
    cyc();                      // strobe accepted on this edge
    m0_stb = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      mid();
      chk("wd_quiet_tmo", 32'(tmo), 32'h0);
      chk("wd_quiet_err", 32'(m0_err), 32'h0);
    end
    cyc();
    exp_q.push_back('{mst: 1'b0, ack: 1'b0, err: 1'b1, dat: 16'h0000});
    mid();
    chk("wd_fire_tmo", 32'(tmo), 32'h1);
    chk("wd_fire_err", 32'(m0_err), 32'h1);
    cyc();
    mid();
    chk("wd_turn_grant", 32'(grant), 32'h0);
    chk("wd_turn_tmo", 32'(tmo), 32'h0);
    chk("wd_turn_outst", 32'(dut.r_outstanding), 32'd0);
    m0_cyc = 1'b0;
    cyc();
    mid();
    chk("wd_idle_grant", 32'(grant), 32'h0);
`else
    // ---- without watchdog the request just waits ----
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0500;
    cyc();
    cyc();
    m0_stb = 1'b0;
    repeat (12) cyc();
    mid();
    chk("nowd_tmo", 32'(tmo), 32'h0);
    chk("nowd_still_owner", 32'(grant), 32'h1);
    chk("nowd_outst", 32'(dut.r_outstanding), 32'd1);
    cyc();
    m0_cyc = 1'b0;
    cyc();
`endif

    cyc();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nor_wb_arbiter.md
NOR_WB_ARBITER -- requirements
Module: nor_wb_arbiter

Interface
REQ-001 Parameter DATABITS, default 16: width of the Wishbone data buses.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: ack-wait limit in clocks; range 2..65535.
REQ-003 Port clk_i, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset_i, input, 1: reset, asynchronous and active-high.
REQ-005 Ports m0_cyc_i, m0_stb_i, m0_we_i, input, 1 each: master 0 (QSPI command FSM) controls.
REQ-006 Ports m0_adr_i (32) and m0_dat_i (DATABITS), input: master 0 address/write data.
REQ-007 Ports m0_ack_o, m0_err_o, m0_stall_o (1 each) and m0_dat_o (DATABITS), output: master 0 responses.
REQ-008 Ports m1_* (inputs and outputs): identical set for master 1 (debug/scan requester).
REQ-009 Ports s_cyc_o, s_stb_o, s_we_o (1), s_adr_o (32), s_dat_o (DATABITS), output: to NOR controller.
REQ-010 Ports s_ack_i, s_err_i, s_stall_i (1), s_dat_i (DATABITS), input: from NOR controller.
REQ-011 Port grant_o, output, 2: one-hot current owner; 00 = idle.
REQ-012 Port timeout_o, output, 1: one-cycle pulse on watchdog expiry.

Function
REQ-013 FSM states: IDLE, OWN0, OWN1, TURN; state register only, all slave outputs muxed combinationally from the owner.
REQ-014 IDLE: exactly one cyc high -> owner state next cycle; both high -> master not granted last (last_q), last_q reset to 1 so m0 wins first.
REQ-015 Grant latency: exactly 1 clock from cyc_i assertion in IDLE to grant_o and s_cyc_o.
REQ-016 OWNx: s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o equal mx_*; mx_ack_o, mx_err_o, mx_stall_o, mx_dat_o equal slave inputs.
REQ-017 Non-owner (and both masters in IDLE/TURN): stall_o=1, ack_o=0, err_o=0, dat_o=0.
REQ-018 IDLE and TURN: s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0.
REQ-019 Owner drops cyc -> TURN next clock, last_q updated to owner; TURN always -> IDLE after one clock.
REQ-020 Outstanding counter (5 bits): +1 on s_stb_o && !s_stall_i, -1 on s_ack_i || s_err_i, net 0 when both same cycle; saturates at 31 and 0.
REQ-021 Ack/err arriving in TURN or IDLE is discarded; counter cleared on entry to TURN.
REQ-022 Owner dropping cyc with outstanding>0 is an abort: s_cyc_o falls with it, no further forwarding.
REQ-023 Owner cannot be pre-empted; the other master waits with stall_o=1 until TURN completes.

Reset
REQ-024 reset_i asserted: state=IDLE, last_q=1, outstanding=0, watchdog=0 immediately, independent of clk_i.
REQ-025 All outputs at reset: s_* = 0, grant_o=00, timeout_o=0, m*_ack_o=0, m*_err_o=0, m*_stall_o=1, m*_dat_o=0.
REQ-026 Reset mid-transaction: s_cyc_o drops asynchronously; no ack/err delivered to any master.
REQ-027 Reset deassertion: first grant possible on the second rising edge after release.

Configuration
REQ-028 Macro NOR_WB_ARBITER_TIMEOUT_EN defined: 16-bit watchdog counts each clock in OWNx with outstanding>0 and no s_ack_i/s_err_i; cleared on ack/err or leaving OWNx.
REQ-029 With macro: on count reaching TIMEOUT_CYCLES-1, owner gets err_o=1 for one clock, timeout_o pulses, outstanding cleared, state -> TURN regardless of owner cyc.
REQ-030 Without macro: no watchdog logic, timeout_o tied 0, arbiter waits indefinitely for ack.

Verification
REQ-031 m0 read adr 0x00000100, slave acks after 3 clocks with 0xBEEF -> grant_o=01 one clock after cyc, m0_dat_o=0xBEEF with m0_ack_o, m1 stall_o=1 throughout.
REQ-032 m0 and m1 raise cyc same clock after reset -> m0 granted; after release and TURN, m1 granted; repeat simultaneous -> m0 granted (round robin).
REQ-033 m1 issues 4 pipelined reads, s_stall_i=1 on second stb -> exactly 4 s_stb_o accepted, outstanding reaches 4, returns 0 after 4 acks.
REQ-034 m0 drops cyc with 2 reads outstanding, late s_ack_i in TURN -> no m0/m1 ack, counter 0, s_cyc_o=0 same cycle as m0_cyc_i low.
REQ-035 Macro defined, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o and timeout_o high 8 clocks after accepted stb, state TURN then IDLE.
REQ-036 reset_i pulsed mid-write from m1 between clock edges -> s_cyc_o low before next edge, grant_o=00, m1_stall_o=1.
